// File: rtl/scan_mux.sv
// scan_mux: registered N-to-1 channel multiplexer with manual select and
// automatic round-robin scanning. Each scanned channel is held for DWELL
// enabled cycles; wrap pulses when the scan returns to channel 0.
module scan_mux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 10,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  dwell_r, dwell_nxt_s;
  logic [SEL_W-1:0]  ch_r, ch_nxt_s;
  logic [WIDTH-1:0]  dout_r, dout_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              wrap_r, wrap_nxt_s;
  logic              sel_legal_s;
  logic [WIDTH-1:0]  mux_s;

  // Pick one channel out of the packed bus; out-of-range indices give zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] res;
    res = {WIDTH{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        res = bus[k*WIDTH +: WIDTH];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign sel_legal_s = (32'(sel) < 32'(CHANNELS));

  // Next-state logic: mode transitions, dwell counting and channel advance.
  always_comb begin
    state_nxt_s = state_r;
    dwell_nxt_s = dwell_r;
    ch_nxt_s    = ch_r;
    valid_nxt_s = valid_r;
    wrap_nxt_s  = 1'b0;
    if (!en) begin
      // Frozen: everything holds, wrap can only ever be a one-cycle pulse.
      wrap_nxt_s = 1'b0;
    end else if (!mode) begin
      state_nxt_s = ST_MANUAL;
      dwell_nxt_s = {CNT_W{1'b0}};
      if (sel_legal_s) begin
        ch_nxt_s    = sel;
        valid_nxt_s = 1'b1;
      end else begin
        ch_nxt_s    = ch_r;
        valid_nxt_s = 1'b0;
      end
    end else begin
      valid_nxt_s = 1'b1;
      case (state_r)
        ST_MANUAL: begin
          // Entering scan always restarts from channel 0 with a fresh dwell.
          state_nxt_s = ST_SCAN;
          dwell_nxt_s = {CNT_W{1'b0}};
          ch_nxt_s    = {SEL_W{1'b0}};
        end
        ST_SCAN: begin
          if (dwell_r == DWELL_LAST) begin
            dwell_nxt_s = {CNT_W{1'b0}};
            if (ch_r == CH_LAST) begin
              ch_nxt_s   = {SEL_W{1'b0}};
              wrap_nxt_s = 1'b1;
            end else begin
              ch_nxt_s   = ch_r + SEL_W'(1);
            end
          end else begin
            dwell_nxt_s = dwell_r + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_MANUAL;
          dwell_nxt_s = {CNT_W{1'b0}};
          ch_nxt_s    = {SEL_W{1'b0}};
          valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  assign mux_s = pick(din, ch_nxt_s);

  // Data path: sample the channel that will be current next cycle.
  always_comb begin
    dout_nxt_s = dout_r;
    if (!en) begin
      dout_nxt_s = dout_r;
    end else if (!mode && !sel_legal_s) begin
      dout_nxt_s = {WIDTH{1'b0}};
    end else begin
      dout_nxt_s = mux_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_MANUAL;
      dwell_r <= {CNT_W{1'b0}};
      ch_r    <= {SEL_W{1'b0}};
      dout_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      dwell_r <= dwell_nxt_s;
      ch_r    <= ch_nxt_s;
      dout_r  <= dout_nxt_s;
      valid_r <= valid_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign dout   = dout_r;
  assign cur_ch = ch_r;
  assign valid  = valid_r;
  assign wrap   = wrap_r;

endmodule

// File: tb/tb_scan_mux.sv
// Directed testbench for scan_mux: three instances cover the default
// configuration, a non-power-of-two channel count, and DWELL=1 scanning.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst, en, mode;

  // u0: defaults (WIDTH=1, CHANNELS=4, DWELL=10)
  logic [1:0]  sel0;
  logic [3:0]  din0;
  logic        dout0, valid0, wrap0;
  logic [1:0]  cur0;
  // u1: WIDTH=4, CHANNELS=3
  logic [1:0]  sel1;
  logic [11:0] din1;
  logic [3:0]  dout1;
  logic        valid1, wrap1;
  logic [1:0]  cur1;
  // u2: CHANNELS=2, DWELL=1
  logic [0:0]  sel2;
  logic [1:0]  din2;
  logic        dout2, valid2, wrap2;
  logic [0:0]  cur2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  scan_mux u0 (.clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel0), .din(din0),
               .dout(dout0), .cur_ch(cur0), .valid(valid0), .wrap(wrap0));

  scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(10)) u1 (
               .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel1), .din(din1),
               .dout(dout1), .cur_ch(cur1), .valid(valid1), .wrap(wrap1));

  scan_mux #(.WIDTH(1), .CHANNELS(2), .DWELL(1)) u2 (
               .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel2), .din(din2),
               .dout(dout2), .cur_ch(cur2), .valid(valid2), .wrap(wrap2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b1;
    step(); step();
    total_cnt++;
    if ({dout0, cur0, valid0, wrap0} !== 5'b0) $display("FAIL reset_u0: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want all 0", dout0, cur0, valid0, wrap0);
    else pass_cnt++;
    total_cnt++;
    if ({dout1, cur1, valid1, wrap1} !== 8'b0) $display("FAIL reset_u1: got dout=%0h cur_ch=%0d valid=%0d wrap=%0d, want all 0", dout1, cur1, valid1, wrap1);
    else pass_cnt++;
    total_cnt++;
    if ({dout2, cur2, valid2, wrap2} !== 4'b0) $display("FAIL reset_u2: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want all 0", dout2, cur2, valid2, wrap2);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_manual();
    logic [1:0] sel_v [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic       exp_d [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    en = 1'b1; mode = 1'b0; din0 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      sel0 = sel_v[i];
      step();
      total_cnt++;
      if ({dout0, cur0, valid0, wrap0} !== {exp_d[i], sel_v[i], 1'b1, 1'b0})
        $display("FAIL manual_sel%0d: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want %0d %0d 1 0",
                 sel_v[i], dout0, cur0, valid0, wrap0, exp_d[i], sel_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal_sel();
    logic [1:0] sel_v [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] exp_d [4] = '{4'hC, 4'h0, 4'hA, 4'hA};
    logic [1:0] exp_c [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
    logic       exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       en_v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    mode = 1'b0; din1 = {4'hC, 4'hB, 4'hA};
    for (int i = 0; i < 4; i++) begin
      sel1 = sel_v[i]; en = en_v[i];
      step();
      total_cnt++;
      if ({dout1, cur1, valid1, wrap1} !== {exp_d[i], exp_c[i], exp_v[i], 1'b0})
        $display("FAIL illegal_sel_step%0d: got dout=%0h cur_ch=%0d valid=%0d wrap=%0d, want %0h %0d %0d 0",
                 i, dout1, cur1, valid1, wrap1, exp_d[i], exp_c[i], exp_v[i]);
      else pass_cnt++;
    end
    en = 1'b1;
  endtask

  task automatic test_scan();
    int ch;
    logic ew;
    din0 = 4'b0101; mode = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      step();
      ch = ((i - 1) / 10) % 4;
      ew = (i == 41);
      total_cnt++;
      if ({dout0, cur0, valid0, wrap0} !== {din0[ch], 2'(ch), 1'b1, ew})
        $display("FAIL scan_cycle%0d: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want %0d %0d 1 %0d",
                 i, dout0, cur0, valid0, wrap0, din0[ch], ch, ew);
      else pass_cnt++;
    end
  endtask

  task automatic test_scan_to_manual();
    mode = 1'b0; sel0 = 2'd2;
    step();
    total_cnt++;
    if ({dout0, cur0, valid0, wrap0} !== {1'b1, 2'd2, 1'b1, 1'b0})
      $display("FAIL scan_to_manual: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want 1 2 1 0", dout0, cur0, valid0, wrap0);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    logic ed;
    mode = 1'b1; din0 = 4'b0101;
    for (int i = 0; i < 14; i++) step();
    total_cnt++;
    if ({dout0, cur0} !== {1'b0, 2'd1}) $display("FAIL freeze_setup: got dout=%0d cur_ch=%0d, want 0 1", dout0, cur0);
    else pass_cnt++;
    en = 1'b0; din0 = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if ({dout0, cur0, valid0, wrap0} !== {1'b0, 2'd1, 1'b1, 1'b0})
        $display("FAIL freeze_hold%0d: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want 0 1 1 0", i, dout0, cur0, valid0, wrap0);
      else pass_cnt++;
    end
    en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      din0 = (j == 2) ? 4'b0111 : 4'b0101;
      ed = (j == 2);
      step();
      total_cnt++;
      if ({dout0, cur0} !== {ed, 2'd1})
        $display("FAIL resume_ch1_%0d: got dout=%0d cur_ch=%0d, want %0d 1", j, dout0, cur0, ed);
      else pass_cnt++;
    end
    din0 = 4'b0101;
    step();
    total_cnt++;
    if ({dout0, cur0, wrap0} !== {1'b1, 2'd2, 1'b0}) $display("FAIL resume_advance: got dout=%0d cur_ch=%0d wrap=%0d, want 1 2 0", dout0, cur0, wrap0);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_scan();
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    total_cnt++;
    if ({dout0, cur0, valid0, wrap0} !== 5'b0) $display("FAIL rst_mid_scan: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want all 0", dout0, cur0, valid0, wrap0);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      total_cnt++;
      if (i <= 10) begin
        if ({dout0, cur0, valid0, wrap0} !== {1'b1, 2'd0, 1'b1, 1'b0})
          $display("FAIL restart_dwell%0d: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want 1 0 1 0", i, dout0, cur0, valid0, wrap0);
        else pass_cnt++;
      end else begin
        if ({dout0, cur0} !== {1'b0, 2'd1})
          $display("FAIL restart_advance: got dout=%0d cur_ch=%0d, want 0 1", dout0, cur0);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_dwell1();
    logic [0:0] ec;
    logic ew;
    din2 = 2'b10; sel2 = 1'b0;
    mode = 1'b0;
    step();
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      ec = 1'(i % 2);
      ew = (i >= 2) && (i % 2 == 0);
      total_cnt++;
      if ({dout2, cur2, valid2, wrap2} !== {din2[ec], ec, 1'b1, ew})
        $display("FAIL dwell1_cycle%0d: got dout=%0d cur_ch=%0d valid=%0d wrap=%0d, want %0d %0d 1 %0d",
                 i, dout2, cur2, valid2, wrap2, din2[ec], ec, ew);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0;
    sel0 = 2'd0; din0 = 4'b0; sel1 = 2'd0; din1 = 12'h0; sel2 = 1'b0; din2 = 2'b0;
    test_reset();
    test_manual();
    test_illegal_sel();
    test_scan();
    test_scan_to_manual();
    test_freeze();
    test_rst_mid_scan();
    test_dwell1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
